// File: rtl/core_mem_responder_if.sv
// Core memory bus: request (addr/wren/wdata/wmask/rden) from core, response (rdata/hit/err) back.
// Latency: none, wires only.
// Backpressure: none; the core holds its request until it samples hit_o.
interface core_mem_responder_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic [AddrWidth-1:0]   addr_i;
  logic                   wren_i;
  logic [DataWidth-1:0]   wdata_i;
  logic [DataWidth/8-1:0] wmask_i;
  logic                   rden_i;
  logic [DataWidth-1:0]   rdata_o;
  logic                   hit_o;
  logic                   err_o;

  // Core side drives requests and consumes responses.
  modport master (
    output addr_i, wren_i, wdata_i, wmask_i, rden_i,
    input  rdata_o, hit_o, err_o
  );

  // Memory side consumes requests and drives responses.
  modport slave (
    input  addr_i, wren_i, wdata_i, wmask_i, rden_i,
    output rdata_o, hit_o, err_o
  );
endinterface

// File: rtl/core_mem_responder.sv
// Word-addressed on-chip RAM endpoint of the core memory bus with programmable wait states.
// Latency: accept at edge T, hit_o high for exactly one cycle after edge T+WaitStates.
// Backpressure: requests are only sampled in IDLE; anything seen in WAIT/RESP is ignored.
module core_mem_responder #(
  parameter int unsigned          AddrWidth  = 32,
  parameter int unsigned          DataWidth  = 32,
  parameter int unsigned          Depth      = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0,
  parameter int unsigned          WaitStates = 1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  core_mem_responder_if.slave bus
);

  localparam int unsigned NumLanes = DataWidth / 8;
  localparam int unsigned LaneBits = $clog2(NumLanes);
  localparam int unsigned IdxBits  = $clog2(Depth);
  localparam logic [3:0]  WsCnt    = 4'(WaitStates);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [NumLanes-1:0]  wmask_q;
  logic                 wr_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 err_q;

  logic [DataWidth-1:0] mem_q [Depth];

  logic                 is_idle;
  logic                 req;
  logic                 accept;
  logic                 enter_resp;
  logic [AddrWidth-1:0] eff_addr;
  logic [DataWidth-1:0] eff_wdata;
  logic [NumLanes-1:0]  eff_wmask;
  logic                 eff_wr;
  logic [AddrWidth-1:0] off;
  logic [AddrWidth-1:0] word_off;
  logic [IdxBits-1:0]   idx;
  logic                 in_range;
  logic                 ram_we;

  assign is_idle = (state_q == IDLE);
  assign req     = bus.rden_i | bus.wren_i;
  assign accept  = is_idle & req;

  // The RAM is accessed on the edge entering RESP. With zero wait states that edge is the
  // acceptance edge itself, so the live request is used; otherwise the latched copy.
  assign enter_resp = (accept && (WaitStates == 0)) || ((state_q == WAIT) && (cnt_q == 4'd1));
  assign eff_addr   = is_idle ? bus.addr_i  : addr_q;
  assign eff_wdata  = is_idle ? bus.wdata_i : wdata_q;
  assign eff_wmask  = is_idle ? bus.wmask_i : wmask_q;
  assign eff_wr     = is_idle ? bus.wren_i  : wr_q;

  // Unsigned offset; an address below BaseAddr wraps here but is rejected by the compare.
  assign off      = eff_addr - BaseAddr;
  assign word_off = off >> LaneBits;
  assign in_range = (eff_addr >= BaseAddr) && (word_off < AddrWidth'(Depth));
  assign idx      = word_off[IdxBits-1:0];

  // Reset gates the RAM write so a write that has not reached its RESP edge is dropped.
  assign ram_we = enter_resp & eff_wr & in_range & ~rst_i;

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = WsCnt;
          state_d = (WaitStates == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on the acceptance edge for use after the wait states.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.addr_i;
      wdata_q <= bus.wdata_i;
      wmask_q <= bus.wmask_i;
      wr_q    <= bus.wren_i;
    end
  end

  // Response data: pre-write word for every access, zero plus err when out of range; held otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      rdata_q <= in_range ? mem_q[idx] : '0;
      err_q   <= ~in_range;
    end
  end

  // Byte-lane masked RAM write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int b = 0; b < NumLanes; b++) begin
        if (eff_wmask[b]) begin
          mem_q[idx][8*b +: 8] <= eff_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.rdata_o = rdata_q;
  assign bus.err_o   = err_q;
  assign bus.hit_o   = (state_q == RESP);

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: one zero-wait instance and one 3-wait instance with offset base.
// Accesses run through a single task that predicts latency, err and read data from a word map.
// The core side holds each request through its hit cycle and drops it in the following IDLE cycle.
module tb_core_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_mem_responder_if #(.AddrWidth(32), .DataWidth(32)) if0 ();
  core_mem_responder_if #(.AddrWidth(32), .DataWidth(32)) if3 ();

  core_mem_responder #(
    .AddrWidth(32), .DataWidth(32), .Depth(1024), .BaseAddr(32'h0), .WaitStates(0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(if0.slave)
  );

  core_mem_responder #(
    .AddrWidth(32), .DataWidth(32), .Depth(256), .BaseAddr(32'h100), .WaitStates(3)
  ) dut3 (
    .clk_i(clk), .rst_i(rst), .bus(if3.slave)
  );

  // Shared request driver, steered to one instance at a time.
  logic        t_sel;
  logic [31:0] t_addr;
  logic        t_wr, t_rd;
  logic [31:0] t_wdata;
  logic [3:0]  t_wmask;

  assign if0.addr_i  = t_addr;
  assign if0.wdata_i = t_wdata;
  assign if0.wmask_i = t_wmask;
  assign if0.wren_i  = t_wr & ~t_sel;
  assign if0.rden_i  = t_rd & ~t_sel;
  assign if3.addr_i  = t_addr;
  assign if3.wdata_i = t_wdata;
  assign if3.wmask_i = t_wmask;
  assign if3.wren_i  = t_wr & t_sel;
  assign if3.rden_i  = t_rd & t_sel;

  wire        o_hit   = t_sel ? if3.hit_o   : if0.hit_o;
  wire        o_err   = t_sel ? if3.err_o   : if0.err_o;
  wire [31:0] o_rdata = t_sel ? if3.rdata_o : if0.rdata_o;

  int nvec = 0;
  int nerr = 0;

  // Reference word map, keyed by instance*65536 + word index; absent means never fully written.
  logic [31:0] mdl [int unsigned];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned base_of(input bit s);
    return s ? 32'h100 : 32'h0;
  endfunction

  function automatic int unsigned depth_of(input bit s);
    return s ? 256 : 1024;
  endfunction

  // One complete access; called at a negedge while the selected instance is idle.
  task automatic access(input bit s, input logic [31:0] a, input bit wr, input bit rd,
                        input logic [31:0] wd, input logic [3:0] wm,
                        output logic [31:0] got, output logic got_err);
    int unsigned b, key, ws;
    bit inr, known, seen;
    logic [31:0] exp_rd, nv;
    int lat;
    b      = base_of(s);
    ws     = s ? 3 : 0;
    inr    = (a >= b) && (((a - b) / 4) < depth_of(s));
    key    = (s ? 65536 : 0) + ((a - b) / 4);
    known  = !inr || mdl.exists(key);
    exp_rd = (inr && known) ? mdl[key] : 32'h0;
    t_sel = s; t_addr = a; t_wr = wr; t_rd = rd; t_wdata = wd; t_wmask = wm;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (o_hit === 1'b1) seen = 1'b1;
    end
    chk("hit_latency", 64'(lat), 64'(ws + 1));
    got = o_rdata;
    got_err = o_err;
    if (seen) begin
      chk("err", {63'b0, o_err}, {63'b0, !inr});
      if (known) chk("rdata", {32'b0, o_rdata}, {32'b0, exp_rd});
      if (wr && inr && (known || wm == 4'hF)) begin
        nv = exp_rd;
        for (int k = 0; k < 4; k++) if (wm[k]) nv[8*k +: 8] = wd[8*k +: 8];
        mdl[key] = nv;
      end
      // Request is still held across the end of the hit cycle; it must not re-execute.
      @(negedge clk);
      chk("hit_one_cycle", {63'b0, o_hit}, 64'b0);
      chk("rdata_hold", {32'b0, o_rdata}, {32'b0, got});
    end
    t_wr = 1'b0;
    t_rd = 1'b0;
  endtask

  logic [31:0] g;
  logic        e;
  int          hits;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    t_sel = 1'b0; t_addr = '0; t_wr = 1'b0; t_rd = 1'b0; t_wdata = '0; t_wmask = '0;
    repeat (3) @(negedge clk);
    chk("rst_hit0",   {63'b0, if0.hit_o},   64'b0);
    chk("rst_err0",   {63'b0, if0.err_o},   64'b0);
    chk("rst_rdata0", {32'b0, if0.rdata_o}, 64'b0);
    chk("rst_hit3",   {63'b0, if3.hit_o},   64'b0);
    chk("rst_err3",   {63'b0, if3.err_o},   64'b0);
    chk("rst_rdata3", {32'b0, if3.rdata_o}, 64'b0);
    rst = 1'b0;
    @(negedge clk);

    // Give the first 16 words of each instance a known value.
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 16; k++)
        access(s[0], base_of(s[0]) + 4 * k, 1'b1, 1'b0, $urandom, 4'hF, g, e);

    // Zero wait states: write then read back.
    access(1'b0, 32'h10, 1'b1, 1'b0, 32'hDEADBEEF, 4'hF, g, e);
    access(1'b0, 32'h10, 1'b0, 1'b1, 32'h0, 4'h0, g, e);
    chk("ws0_readback", {32'b0, g}, 64'hDEADBEEF);

    // Partial byte mask.
    access(1'b0, 32'h20, 1'b1, 1'b0, 32'h11223344, 4'hF, g, e);
    access(1'b0, 32'h20, 1'b1, 1'b0, 32'hAABBCCDD, 4'h5, g, e);
    access(1'b0, 32'h20, 1'b0, 1'b1, 32'h0, 4'h0, g, e);
    chk("byte_mask", {32'b0, g}, 64'h11BB33DD);

    // Out of range above the RAM; word 0 must survive.
    access(1'b0, 32'h0, 1'b1, 1'b0, 32'h0BADF00D, 4'hF, g, e);
    access(1'b0, 32'h1000, 1'b1, 1'b0, 32'hFFFFFFFF, 4'hF, g, e);
    chk("oor_wr_err", {63'b0, e}, 64'h1);
    access(1'b0, 32'h1000, 1'b0, 1'b1, 32'h0, 4'h0, g, e);
    chk("oor_rd_err", {63'b0, e}, 64'h1);
    chk("oor_rd_data", {32'b0, g}, 64'h0);
    access(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 4'h0, g, e);
    chk("word0_intact", {32'b0, g}, 64'h0BADF00D);

    // Write and read together: old value returned, new value stored.
    access(1'b0, 32'h30, 1'b1, 1'b0, 32'h5, 4'hF, g, e);
    access(1'b0, 32'h30, 1'b1, 1'b1, 32'h7, 4'hF, g, e);
    chk("wr_rd_old", {32'b0, g}, 64'h5);
    access(1'b0, 32'h30, 1'b0, 1'b1, 32'h0, 4'h0, g, e);
    chk("wr_rd_new", {32'b0, g}, 64'h7);

    // Three wait states with offset base: range edges on both sides.
    access(1'b1, 32'hFC,  1'b0, 1'b1, 32'h0, 4'h0, g, e);
    chk("below_base_err", {63'b0, e}, 64'h1);
    access(1'b1, 32'h4FC, 1'b0, 1'b1, 32'h0, 4'h0, g, e);
    chk("last_word_err", {63'b0, e}, 64'h0);
    access(1'b1, 32'h500, 1'b0, 1'b1, 32'h0, 4'h0, g, e);
    chk("past_end_err", {63'b0, e}, 64'h1);

    // Reset during WAIT of a write: no hit, write dropped, next access has normal latency.
    access(1'b1, 32'h140, 1'b1, 1'b0, 32'hCAFE0001, 4'hF, g, e);
    t_sel = 1'b1; t_addr = 32'h140; t_wr = 1'b1; t_rd = 1'b0; t_wdata = 32'h12345678; t_wmask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    t_wr = 1'b0;
    hits = 0;
    repeat (2) begin
      @(negedge clk);
      if (o_hit === 1'b1) hits++;
    end
    chk("rst_mid_rdata", {32'b0, o_rdata}, 64'h0);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (o_hit !== 1'b0) hits++;
    end
    chk("rst_mid_nohit", 64'(hits), 64'h0);
    access(1'b1, 32'h140, 1'b0, 1'b1, 32'h0, 4'h0, g, e);
    chk("rst_mid_word", {32'b0, g}, 64'hCAFE0001);

    // Randomized accesses across both instances.
    for (int i = 0; i < 150; i++) begin
      bit s;
      int unsigned r, k, b, d;
      logic [31:0] a;
      s = 1'($urandom_range(0, 1));
      b = base_of(s);
      d = depth_of(s);
      r = $urandom_range(0, 9);
      if (r < 7)                a = b + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      else if (r == 7 && s)     a = $urandom_range(0, 32'hFF);
      else                      a = b + 4 * d + $urandom_range(0, 255);
      k = $urandom_range(1, 3);
      access(s, a, k[0], k[1], $urandom, 4'($urandom_range(0, 15)), g, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
